// File: rtl/ct_spsram_init_ctrl.sv
// ct_spsram_init_ctrl: sweeps INIT_VALUE into a single-port SRAM on request and forwards functional traffic when idle.
// Define CT_SPSRAM_INIT_VERIFY_EN to add a read-back verify pass with sticky error capture.
module ct_spsram_init_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 23,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] init_err_addr,
    input  logic                  func_cen,
    input  logic                  func_gwen,
    input  logic [DATA_WIDTH-1:0] func_wen,
    input  logic [ADDR_WIDTH-1:0] func_addr,
    input  logic [DATA_WIDTH-1:0] func_din,
    output logic                  func_ready,
    output logic [DATA_WIDTH-1:0] func_dout,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef CT_SPSRAM_INIT_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
`endif

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  start_acc;
    logic                  cnt_last;

    assign start_acc = init_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Termination is on the all-ones compare, so the counter never relies on overflow.
    assign cnt_last  = (cnt_q == '1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_last) begin
`ifdef CT_SPSRAM_INIT_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef CT_SPSRAM_INIT_VERIFY_EN
            ST_VERIFY: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_last) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == ST_DONE);

`ifdef CT_SPSRAM_INIT_VERIFY_EN
    logic                  cmp_vld_q, cmp_vld_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    // sram_q answers the read issued last cycle, so the compared address lags by one.
    assign cmp_vld_d  = (state_q == ST_VERIFY);
    assign cmp_addr_d = cnt_q;

    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (start_acc) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (cmp_vld_q && (sram_q != INIT_VALUE) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = cmp_addr_q;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= cmp_addr_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign init_err      = err_q;
    assign init_err_addr = err_addr_q;
    assign init_busy     = (state_q == ST_WRITE) || (state_q == ST_VERIFY) || (state_q == ST_DRAIN);
`else
    assign init_err      = 1'b0;
    assign init_err_addr = '0;
    assign init_busy     = (state_q == ST_WRITE);
`endif

    assign func_ready = !init_busy;
    assign func_dout  = sram_q;

    always_comb begin
        sram_a    = func_addr;
        sram_cen  = func_cen;
        sram_gwen = func_gwen;
        sram_wen  = func_wen;
        sram_d    = func_din;
        case (state_q)
            ST_WRITE: begin
                sram_a    = cnt_q;
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_d    = INIT_VALUE;
            end
`ifdef CT_SPSRAM_INIT_VERIFY_EN
            ST_VERIFY: begin
                sram_a    = cnt_q;
                sram_cen  = 1'b0;
                sram_gwen = 1'b1;
                sram_wen  = '1;
                sram_d    = INIT_VALUE;
            end
            ST_DRAIN: begin
                sram_a    = cnt_q;
                sram_cen  = 1'b1;
                sram_gwen = 1'b1;
                sram_wen  = '1;
                sram_d    = INIT_VALUE;
            end
`endif
            default: ;
        endcase
    end

endmodule
